// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake, redirect/halt control and status.
interface ifetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output halted,
        output fault,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  halted,
        input  fault,
        input  fetch_count
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational instruction memory and
// hands registered (pc, instr) pairs to decode, with redirect, halt and fault handling.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     reset,
    ifetch_if.master bus
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        load_ok;
    logic        accept;
    logic        redirect_legal;

    assign bus.imem_addr  = pc;
    assign load_ok        = !bus.if_valid || bus.id_ready;
    // A redirect in the same cycle squashes the held instruction, so it is not counted.
    assign accept         = bus.if_valid && bus.id_ready && !bus.redirect_valid;
    assign redirect_legal = (bus.redirect_pc[1:0] == 2'b00) && (bus.redirect_pc < MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            bus.if_valid    <= 1'b0;
            bus.if_instr    <= NOP_INSTR;
            bus.if_pc       <= 32'h0;
            bus.halted      <= 1'b0;
            bus.fault       <= 1'b0;
            bus.fetch_count <= 32'h0;
        end else begin
            if (accept) begin
                bus.fetch_count <= bus.fetch_count + 32'd1;
            end

            unique case (state)
                IDLE: begin
                    state <= RUN;
                end

                RUN: begin
                    if (bus.redirect_valid) begin
                        if (redirect_legal) begin
                            pc <= bus.redirect_pc;
                        end else begin
                            state     <= FAULT;
                            bus.fault <= 1'b1;
                        end
                        bus.if_valid <= 1'b0;
                        bus.if_instr <= NOP_INSTR;
                    end else if (bus.halt_req) begin
                        state      <= HALTED;
                        bus.halted <= 1'b1;
                        if (accept) begin
                            bus.if_valid <= 1'b0;
                            bus.if_instr <= NOP_INSTR;
                        end
                    end else if (load_ok) begin
                        if (pc >= MEM_LIMIT) begin
                            state        <= FAULT;
                            bus.fault    <= 1'b1;
                            bus.if_valid <= 1'b0;
                            bus.if_instr <= NOP_INSTR;
                        end else begin
                            bus.if_valid <= 1'b1;
                            bus.if_instr <= bus.imem_instr;
                            bus.if_pc    <= pc;
                            pc           <= pc + 32'd4;
                        end
                    end
                end

                HALTED: begin
                    if (bus.redirect_valid) begin
                        if (redirect_legal) begin
                            state <= RUN;
                            pc    <= bus.redirect_pc;
                        end else begin
                            state     <= FAULT;
                            bus.fault <= 1'b1;
                        end
                        bus.halted   <= 1'b0;
                        bus.if_valid <= 1'b0;
                        bus.if_instr <= NOP_INSTR;
                    end else if (accept) begin
                        bus.if_valid <= 1'b0;
                        bus.if_instr <= NOP_INSTR;
                    end
                end

                FAULT: begin
                    state <= FAULT;
                end

                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed vector table, boundary sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_ifetch_ctrl;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] XA    = 32'hFFFF_FFFF;
    localparam logic [31:0] LIMIT = 32'h0000_0400;

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        logic        hlt;
        logic        ev;
        logic [31:0] epc, ei, ea;
        logic        eh, ef;
        logic [31:0] ec;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem [256];
    int          n_checks;
    int          n_fail;

    // reference model state
    logic [31:0] m_pc, m_instr, m_ifpc, m_count;
    logic        m_valid, m_warm, m_halted, m_fault;

    ifetch_if bus();

    ifetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.imem_instr = (bus.imem_addr < LIMIT) ? mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic hlt, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ei,
                                input logic [31:0] ea, input logic eh, input logic ef,
                                input logic [31:0] ec);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.ev = ev; v.epc = epc; v.ei = ei; v.ea = ea; v.eh = eh; v.ef = ef; v.ec = ec;
        return v;
    endfunction

    // Behavioural model: one call per clock edge, using the inputs about to be sampled.
    task automatic model_step(input logic rst, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic hlt);
        logic taken, legal;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0; m_count = 32'h0;
            m_warm = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
            return;
        end
        taken = m_valid && rdy && !rv;
        legal = (rpc % 4 == 0) && (rpc < LIMIT);
        if (taken) m_count = m_count + 1;
        if (m_fault) begin
            // sticky: nothing moves
        end else if (!m_warm) begin
            m_warm = 1'b1;
        end else if (rv) begin
            if (legal) m_pc = rpc;
            else m_fault = 1'b1;
            m_halted = 1'b0;
            m_valid  = 1'b0;
        end else if (m_halted || hlt) begin
            m_halted = 1'b1;
            if (taken) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            if (m_pc >= LIMIT) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_instr = mem[m_pc[9:2]];
                m_ifpc  = m_pc;
                m_pc    = m_pc + 4;
            end
        end
        if (!m_valid) m_instr = NOP;
    endtask

    task automatic step(input logic rst, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic hlt);
        reset              = rst;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt_req       = hlt;
        model_step(rst, rdy, rv, rpc, hlt);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [31];

    initial begin
        logic [31:0] rpc;
        int          r;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.halt_req = 1'b0;

        mem[0] = 32'h003100B3; // add x1,x2,x3
        mem[1] = 32'h40628233; // sub x4,x5,x6
        mem[2] = 32'h009473B3; // and x7,x8,x9
        mem[3] = 32'h00C5E533; // or  x10,x11,x12
        mem[4] = 32'h00073683; // ld  x13,0(x14)
        mem[5] = 32'h00F83423; // sd  x15,8(x16)
        mem[6] = 32'h01288463; // beq x17,x18,8
        for (int i = 7; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);

        //             rst rdy rv rpc       hlt  ev  epc     instr   addr   h  f  cnt
        tbl[0]  = mk(1, 1, 0, 32'h0,   0,   0, 32'h0,  NOP,    32'h0,  0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 32'h0,   0,   0, 32'h0,  NOP,    32'h0,  0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 32'h0,   0,   1, 32'h0,  mem[0], 32'h4,  0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 32'h0,   0,   1, 32'h4,  mem[1], 32'h8,  0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 32'h0,   0,   1, 32'h8,  mem[2], 32'hC,  0, 0, 2);
        tbl[5]  = mk(0, 0, 0, 32'h0,   0,   1, 32'h8,  mem[2], 32'hC,  0, 0, 2);
        tbl[6]  = mk(0, 0, 0, 32'h0,   0,   1, 32'h8,  mem[2], 32'hC,  0, 0, 2);
        tbl[7]  = mk(0, 0, 0, 32'h0,   0,   1, 32'h8,  mem[2], 32'hC,  0, 0, 2);
        tbl[8]  = mk(0, 1, 0, 32'h0,   0,   1, 32'hC,  mem[3], 32'h10, 0, 0, 3);
        tbl[9]  = mk(0, 1, 0, 32'h0,   0,   1, 32'h10, mem[4], 32'h14, 0, 0, 4);
        tbl[10] = mk(0, 1, 0, 32'h0,   0,   1, 32'h14, mem[5], 32'h18, 0, 0, 5);
        tbl[11] = mk(0, 1, 0, 32'h0,   0,   1, 32'h18, mem[6], 32'h1C, 0, 0, 6);
        tbl[12] = mk(0, 1, 0, 32'h0,   0,   1, 32'h1C, mem[7], 32'h20, 0, 0, 7);
        tbl[13] = mk(0, 1, 1, 32'h8,   0,   0, 32'h0,  NOP,    32'h8,  0, 0, 7);
        tbl[14] = mk(0, 1, 0, 32'h0,   0,   1, 32'h8,  mem[2], 32'hC,  0, 0, 7);
        tbl[15] = mk(0, 1, 1, 32'h18,  0,   0, 32'h0,  NOP,    32'h18, 0, 0, 7);
        tbl[16] = mk(0, 1, 0, 32'h0,   0,   1, 32'h18, mem[6], 32'h1C, 0, 0, 7);
        tbl[17] = mk(0, 1, 1, 32'h4,   0,   0, 32'h0,  NOP,    32'h4,  0, 0, 7);
        tbl[18] = mk(0, 0, 0, 32'h0,   0,   1, 32'h4,  mem[1], 32'h8,  0, 0, 7);
        tbl[19] = mk(0, 0, 0, 32'h0,   1,   1, 32'h4,  mem[1], 32'h8,  1, 0, 7);
        tbl[20] = mk(0, 0, 0, 32'h0,   0,   1, 32'h4,  mem[1], 32'h8,  1, 0, 7);
        tbl[21] = mk(0, 1, 0, 32'h0,   0,   0, 32'h0,  NOP,    32'h8,  1, 0, 8);
        tbl[22] = mk(0, 1, 0, 32'h0,   1,   0, 32'h0,  NOP,    32'h8,  1, 0, 8);
        tbl[23] = mk(0, 1, 1, 32'h0,   0,   0, 32'h0,  NOP,    32'h0,  0, 0, 8);
        tbl[24] = mk(0, 1, 0, 32'h0,   0,   1, 32'h0,  mem[0], 32'h4,  0, 0, 8);
        tbl[25] = mk(0, 1, 1, 32'h402, 0,   0, 32'h0,  NOP,    XA,     0, 1, 8);
        tbl[26] = mk(0, 1, 1, 32'h0,   1,   0, 32'h0,  NOP,    XA,     0, 1, 8);
        tbl[27] = mk(1, 1, 0, 32'h0,   0,   0, 32'h0,  NOP,    32'h0,  0, 0, 0);
        tbl[28] = mk(0, 0, 0, 32'h0,   0,   0, 32'h0,  NOP,    32'h0,  0, 0, 0);
        tbl[29] = mk(0, 0, 0, 32'h0,   0,   1, 32'h0,  mem[0], 32'h4,  0, 0, 0);
        tbl[30] = mk(1, 0, 0, 32'h0,   0,   0, 32'h0,  NOP,    32'h0,  0, 0, 0);

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].hlt);
            chk($sformatf("row%0d if_valid", i), 32'(bus.if_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d if_instr", i), bus.if_instr, tbl[i].ei);
            if (tbl[i].ev || tbl[i].rst) chk($sformatf("row%0d if_pc", i), bus.if_pc, tbl[i].epc);
            if (tbl[i].ea != XA) chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].ea);
            chk($sformatf("row%0d halted", i), 32'(bus.halted), 32'(tbl[i].eh));
            chk($sformatf("row%0d fault", i), 32'(bus.fault), 32'(tbl[i].ef));
            chk($sformatf("row%0d fetch_count", i), bus.fetch_count, tbl[i].ec);
        end

        // Sequential fetch runs off the end of memory; fault waits for load_ok.
        step(1, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        for (int k = 0; k < 256; k++) step(0, 1, 0, 32'h0, 0);
        chk("edge last valid", 32'(bus.if_valid), 32'd1);
        chk("edge last if_pc", bus.if_pc, 32'h3FC);
        chk("edge last instr", bus.if_instr, mem[255]);
        chk("edge pc at limit", bus.imem_addr, LIMIT);
        chk("edge count", bus.fetch_count, 32'd255);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("edge stall no fault", 32'(bus.fault), 32'd0);
        chk("edge stall if_pc", bus.if_pc, 32'h3FC);
        step(0, 1, 0, 32'h0, 0);
        chk("seq fault", 32'(bus.fault), 32'd1);
        chk("seq fault valid", 32'(bus.if_valid), 32'd0);
        chk("seq fault instr", bus.if_instr, NOP);
        chk("seq fault count", bus.fetch_count, 32'd256);
        step(0, 1, 1, 32'h10, 0);
        chk("fault ignores redirect", 32'(bus.fault), 32'd1);
        chk("fault ignores redirect valid", 32'(bus.if_valid), 32'd0);
        step(1, 1, 0, 32'h0, 0);
        chk("fault cleared by reset", 32'(bus.fault), 32'd0);
        chk("reset pc", bus.imem_addr, 32'h0);

        // Redirect and halt together: redirect wins, halt taken the next cycle.
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 1, 32'h10, 1);
        chk("redir+halt halted", 32'(bus.halted), 32'd0);
        chk("redir+halt pc", bus.imem_addr, 32'h10);
        step(0, 1, 0, 32'h0, 1);
        chk("halt after redir", 32'(bus.halted), 32'd1);
        chk("halt after redir valid", 32'(bus.if_valid), 32'd0);

        // Randomized traffic against the reference model.
        step(1, 1, 0, 32'h0, 0);
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (r == 7) rpc = 32'h3F0 + 32'(4 * $urandom_range(0, 3));
            else if (r == 8) rpc = $urandom;
            else             rpc = ($urandom_range(0, 1) == 0) ? 32'h400 : 32'h3FE;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 19) == 0));
            chk($sformatf("rnd%0d if_valid", c), 32'(bus.if_valid), 32'(m_valid));
            chk($sformatf("rnd%0d if_instr", c), bus.if_instr, m_instr);
            if (m_valid) chk($sformatf("rnd%0d if_pc", c), bus.if_pc, m_ifpc);
            if (!m_fault) chk($sformatf("rnd%0d imem_addr", c), bus.imem_addr, m_pc);
            chk($sformatf("rnd%0d halted", c), 32'(bus.halted), 32'(m_halted));
            chk($sformatf("rnd%0d fault", c), 32'(bus.fault), 32'(m_fault));
            chk($sformatf("rnd%0d fetch_count", c), bus.fetch_count, m_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle RISC-V core.
- Owns the PC and drives the word-addressed, combinational-read instruction memory (256 x 32, indexed by address[31:2]).
- Registers each fetched word plus its PC toward decode over a valid/ready handshake.
- Handles branch/jump redirects, halt requests and out-of-range/misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 256, instruction memory depth in words; legal fetch range is 0 to MEM_WORDS*4-4.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when no valid instruction is held.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to the instruction memory; combinationally equal to pc.
- imem_instr  in  32  instruction word returned combinationally by the memory.
- if_valid  out  1  if_instr and if_pc hold a fetched instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  byte address of if_instr.
- id_ready  in  1  decode accepts the instruction this cycle.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target, byte address.
- halt_req  in  1  stop fetching.
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT (sticky until reset).
- fetch_count  out  32  number of instructions accepted by decode.

Behaviour:
- Reset, on a clk edge with reset=1:
  - pc=RESET_PC, state=IDLE.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0.
  - halted=0, fault=0, fetch_count=0.
  - Reset overrides everything, including mid-handshake.
- States: IDLE, RUN, HALTED, FAULT.
- IDLE: no fetch for one cycle, then RUN unconditionally. The first if_valid=1 appears 2 cycles after reset deasserts.
- Load condition: load_ok = (!if_valid || id_ready).
- RUN, evaluated each cycle in this priority order:
  1. redirect_valid=1:
     - If redirect_pc[1:0]!=0 or redirect_pc >= MEM_WORDS*4: go to FAULT, if_valid<=0.
     - Otherwise pc<=redirect_pc, if_valid<=0 (flushes the held instruction, even if id_ready=1 this cycle).
     - No capture this cycle; the redirected instruction appears the following cycle.
  2. halt_req=1: go to HALTED. No new capture; a held instruction stays valid until accepted.
  3. pc >= MEM_WORDS*4 and load_ok: go to FAULT, if_valid<=0.
  4. load_ok: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit wrap).
  5. Otherwise (stall): pc and the output registers hold.
- Throughput: 1 instruction/cycle while id_ready=1.
- HALTED:
  - No capture; the held if_valid drains on id_ready.
  - redirect_valid with a legal target: pc<=redirect_pc, if_valid<=0, go to RUN.
  - redirect_valid with an illegal target: go to FAULT.
  - halt_req is ignored.
- FAULT:
  - No capture; all inputs except reset are ignored.
  - if_valid=0, if_instr=NOP_INSTR; pc holds the faulting value.
- Whenever if_valid=0 after a clock edge, if_instr=NOP_INSTR.
- fetch_count increments by 1 on every cycle with if_valid && id_ready and no redirect in the same cycle. It wraps 2^32-1 -> 0.
- Simultaneous redirect_valid and halt_req in RUN: the redirect wins; halt_req is re-sampled next cycle.

Test Plan:
- Streaming:
  - Stimulus: release reset with id_ready=1; memory words 0..6 = add, sub, and, or, ld, sd, beq encodings.
  - Response: if_valid rises on cycle 2; (if_pc, if_instr) = (0, 0x003100B3), (4, 0x40628233), ... one per cycle; fetch_count=7 after 7 accepts.
- Backpressure:
  - Stimulus: id_ready=0 for 3 cycles while if_pc=8.
  - Response: if_pc=8, if_instr=0x009473B3 held stable; pc=12 held; no count increment; resumes at pc 12 when id_ready=1.
- Redirect:
  - Stimulus: redirect_valid=1, redirect_pc=0x18 while if_pc=8 valid with id_ready=1.
  - Response: next cycle if_valid=0, fetch_count unchanged; the cycle after, if_pc=0x18, if_instr=beq word.
- Halt and resume:
  - Stimulus: halt_req=1 while id_ready=0 and if_pc=4 is held.
  - Response: halted=1; if_pc=4 is still delivered on id_ready; no further fetch; a later redirect to 0 returns to RUN with if_pc=0.
- Faults:
  - Stimulus: (a) redirect_pc=0x0000_0402; (b) sequential fetch reaches pc=0x400.
  - Response: fault=1, if_valid=0; inputs ignored; reset returns to IDLE with pc=0.
- Reset mid-stream:
  - Stimulus: assert reset while if_valid=1 with id_ready=0.
  - Response: next edge if_valid=0, if_instr=0x00000013, fetch_count=0.
